// File: rtl/regbank_pkg.sv
// Shared sizing defaults and requester ids for the arbitrated register bank.
package regbank_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 4;
    localparam int ADDR_W    = $clog2(DEPTH_DEF);
    localparam int REQ0      = 0;
    localparam int REQ1      = 1;
endpackage

// File: rtl/regbank_store.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
module regbank_store
    import regbank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_d, mem_q;

    // Next-state: overwrite the addressed entry on a write, hold everything else.
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // Storage flops, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    // Read sees the value held before the current edge.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/regbank_arbiter.sv
// Two-requester round-robin front end to a register bank, with a 1-cycle
// read-response pipeline and a wrapping handshake counter.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             req1_ready,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [7:0]       grant_cnt
);

    // ptr_q names the requester that wins a tie; 0 after reset.
    logic             ptr_d, ptr_q;
    logic [1:0]       rsp_valid_d, rsp_valid_q;
    logic [WIDTH-1:0] rsp_rdata_d, rsp_rdata_q;
    logic [7:0]       grant_cnt_d, grant_cnt_q;

    logic             hs0, hs1;
    logic             st_we;
    logic [AW-1:0]    st_addr;
    logic [WIDTH-1:0] st_wdata;
    logic [WIDTH-1:0] st_rdata;

    // Grant: a lone requester wins, a tie goes to the pointer; nothing while in reset.
    always_comb begin
        req0_ready = !rst && req0_valid && (!req1_valid || (ptr_q == 1'(REQ0)));
        req1_ready = !rst && req1_valid && (!req0_valid || (ptr_q == 1'(REQ1)));
        hs0        = req0_valid && req0_ready;
        hs1        = req1_valid && req1_ready;
    end

    // Steer the granted request onto the single store port.
    always_comb begin
        st_addr  = hs1 ? req1_addr  : req0_addr;
        st_wdata = hs1 ? req1_wdata : req0_wdata;
        st_we    = (hs0 && req0_we) || (hs1 && req1_we);
    end

    regbank_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (st_we),
        .waddr (st_addr),
        .wdata (st_wdata),
        .raddr (st_addr),
        .rdata (st_rdata)
    );

    // Pointer, response and counter next-state.
    always_comb begin
        ptr_d = ptr_q;
        if (hs0)      ptr_d = 1'(REQ1);
        else if (hs1) ptr_d = 1'(REQ0);

        rsp_valid_d       = '0;
        rsp_valid_d[REQ0] = hs0 && !req0_we;
        rsp_valid_d[REQ1] = hs1 && !req1_we;
        rsp_rdata_d       = (|rsp_valid_d) ? st_rdata : '0;

        grant_cnt_d = grant_cnt_q;
        if (hs0 || hs1) grant_cnt_d = grant_cnt_q + 8'd1;
    end

    // State flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= 1'(REQ0);
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    // Masking with rst drops a response whose read was accepted just before reset.
    always_comb begin
        rsp_valid = rst ? 2'b00 : rsp_valid_q;
        rsp_rdata = rst ? '0    : rsp_rdata_q;
        grant_cnt = grant_cnt_q;
    end

endmodule
